// File: rtl/fuzzy_pkg.sv
// Shared fuzzy datapath types and constants.
// Membership/singleton formats and the defuzzifier state encoding.
package fuzzy_pkg;

  localparam int MU_WIDTH   = 16;
  localparam int S_WIDTH    = 8;
  localparam int QMAG_WIDTH = 9;

  typedef logic [MU_WIDTH-1:0]       mu_t;
  typedef logic signed [S_WIDTH-1:0] sval_t;

  localparam mu_t MU_ONE = '1;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    DIV,
    DONE
  } defuzz_state_t;

endpackage

// File: rtl/udiv_serial.sv
// Unsigned restoring bit-serial divider, one quotient bit per cycle.
// Ports: clk, rst, start, dividend, divisor -> busy, done (1-cycle pulse), quotient.
module udiv_serial #(
  parameter int DVD_W = 27,
  parameter int DVS_W = 18,
  parameter int Q_W   = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [Q_W-1:0]   quotient
);

  localparam int R_W = DVS_W + 1;
  localparam int C_W = $clog2(Q_W + 1);

  logic [R_W-1:0]   rem, rem_src, trial, rem_nx;
  logic [Q_W-1:0]   lo, lo_src, lo_nx;
  logic [DVS_W-1:0] dvs, dvs_src;
  logic [C_W-1:0]   cnt;
  logic             ge;

  // The first step runs on the start edge; the upper dividend bits
  // seed the remainder (the caller guarantees quotient < 2^Q_W).
  always_comb begin
    rem_src = start ? R_W'(dividend[DVD_W-1:Q_W]) : rem;
    lo_src  = start ? dividend[Q_W-1:0] : lo;
    dvs_src = start ? divisor : dvs;
    trial   = {rem_src[R_W-2:0], lo_src[Q_W-1]};
    ge      = trial >= {1'b0, dvs_src};
    rem_nx  = ge ? trial - {1'b0, dvs_src} : trial;
    lo_nx   = {lo_src[Q_W-2:0], ge};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem  <= '0;
      lo   <= '0;
      dvs  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem  <= rem_nx;
        lo   <= lo_nx;
        dvs  <= dvs_src;
        cnt  <= C_W'(1);
        busy <= 1'b1;
      end else if (busy) begin
        rem <= rem_nx;
        lo  <= lo_nx;
        cnt <= cnt + C_W'(1);
        if (cnt == C_W'(Q_W - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient = lo;

endmodule

// File: rtl/defuzzifier_wavg.sv
// Weighted-average defuzzifier: serial MAC then serial divide, y = sum(mu*s)/sum(mu).
// Ports: clk, rst, in_valid/in_ready, mu_*, s_* in; out_valid/out_ready, y, div_zero out.
module defuzzifier_wavg
  import fuzzy_pkg::*;
#(
  parameter int MU_W   = MU_WIDTH,
  parameter int S_W    = S_WIDTH,
  parameter int QMAG_W = QMAG_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [MU_W-1:0]       mu_neg,
  input  logic [MU_W-1:0]       mu_zero,
  input  logic [MU_W-1:0]       mu_pos,
  input  logic signed [S_W-1:0] s_neg,
  input  logic signed [S_W-1:0] s_zero,
  input  logic signed [S_W-1:0] s_pos,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [S_W-1:0] y,
  output logic                  div_zero
);

  localparam int P_W   = MU_W + S_W + 1;
  localparam int NUM_W = P_W + 2;
  localparam int DEN_W = MU_W + 2;
  localparam int SMAX  = 2 ** (S_W - 1) - 1;
  localparam int SMIN  = -(2 ** (S_W - 1));

  defuzz_state_t state, state_nx;

  logic [MU_W-1:0]          mn, mz, mp, mu_sel;
  logic signed [S_W-1:0]    sn, sz, sp, s_sel;
  logic [1:0]               idx;
  logic signed [NUM_W-1:0]  num, num_nx;
  logic [DEN_W-1:0]         den, den_nx;
  logic signed [P_W-1:0]    prod;
  logic [NUM_W-1:0]         num_abs;
  logic                     div_start, div_busy, div_done;
  logic [QMAG_W-1:0]        q;
  logic signed [QMAG_W:0]   sq;
  int                       sq_i;
  logic signed [S_W-1:0]    y_sat;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // MAC takes idx 0..2 for neg/zero/pos; idx 3 is the decision cycle.
  always_comb begin
    state_nx  = state;
    div_start = 1'b0;
    unique case (state)
      IDLE: if (in_valid) state_nx = MAC;
      MAC: begin
        if (idx == 2'd3) begin
          if (den == '0) begin
            state_nx = DONE;
          end else if (!div_busy) begin
            state_nx  = DIV;
            div_start = 1'b1;
          end
        end
      end
      DIV:  if (div_done) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    mu_sel = mp;
    s_sel  = sp;
    unique case (idx)
      2'd0: begin mu_sel = mn; s_sel = sn; end
      2'd1: begin mu_sel = mz; s_sel = sz; end
      default: begin mu_sel = mp; s_sel = sp; end
    endcase
    prod = $signed({{S_W{1'b0}}, mu_sel})
         * $signed({{(P_W-S_W){s_sel[S_W-1]}}, s_sel});
    num_nx = num + $signed({{(NUM_W-P_W){prod[P_W-1]}}, prod});
    den_nx = den + DEN_W'(mu_sel);
    num_abs = num[NUM_W-1] ? NUM_W'(-num) : NUM_W'(num);
  end

  // Reapply the sign of num and clamp to the output range.
  always_comb begin
    sq    = num[NUM_W-1] ? -$signed({1'b0, q}) : $signed({1'b0, q});
    sq_i  = int'(sq);
    y_sat = S_W'(sq);
    if (sq_i > SMAX)      y_sat = S_W'(SMAX);
    else if (sq_i < SMIN) y_sat = S_W'(SMIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mn <= '0; mz <= '0; mp <= '0;
      sn <= '0; sz <= '0; sp <= '0;
      idx      <= '0;
      num      <= '0;
      den      <= '0;
      y        <= '0;
      div_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            mn <= mu_neg; mz <= mu_zero; mp <= mu_pos;
            sn <= s_neg;  sz <= s_zero;  sp <= s_pos;
            idx <= '0;
            num <= '0;
            den <= '0;
          end
        end
        MAC: begin
          if (idx != 2'd3) begin
            num <= num_nx;
            den <= den_nx;
            idx <= idx + 2'd1;
          end else if (den == '0) begin
            y        <= '0;
            div_zero <= 1'b1;
          end
        end
        DIV: begin
          if (div_done) begin
            y        <= y_sat;
            div_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  udiv_serial #(
    .DVD_W(NUM_W),
    .DVS_W(DEN_W),
    .Q_W  (QMAG_W)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .start   (div_start),
    .dividend(num_abs),
    .divisor (den),
    .busy    (div_busy),
    .done    (div_done),
    .quotient(q)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

endmodule
